// File: rtl/vend_sell_if.sv
// Customer-side bus of the vending purchase controller: switches, keypad
// edges and stock in; sold counters and transaction display values out.
interface vend_sell_if;
    logic        sw1;
    logic        sw2;
    logic        sw3;
    logic        sw4;
    logic [15:0] key_edge;
    logic [3:0]  quant1;
    logic [3:0]  quant2;
    logic [3:0]  quant3;
    logic [3:0]  quant4;
    logic [3:0]  count1;
    logic [3:0]  count2;
    logic [3:0]  count3;
    logic [3:0]  count4;
    logic [2:0]  state;
    logic [1:0]  product;
    logic [3:0]  qty;
    logic [7:0]  total;
    logic [7:0]  paid;
    logic [7:0]  change;
    logic        done;
    logic        refund;
    logic        fail;

    modport master (
        output sw1, sw2, sw3, sw4, key_edge, quant1, quant2, quant3, quant4,
        input  count1, count2, count3, count4, state, product, qty, total,
               paid, change, done, refund, fail
    );

    modport slave (
        input  sw1, sw2, sw3, sw4, key_edge, quant1, quant2, quant3, quant4,
        output count1, count2, count3, count4, state, product, qty, total,
               paid, change, done, refund, fail
    );
endinterface

// File: rtl/vend_sell.sv
// Purchase controller: product/quantity selection against stock, coin
// payment with cancel and idle timeout, dispense into cumulative counters.
module vend_sell #(
    parameter int PRICE1  = 3,
    parameter int PRICE2  = 5,
    parameter int PRICE3  = 7,
    parameter int PRICE4  = 10,
    parameter int TIMEOUT = 100_000_000,
    parameter int HOLD    = 200_000_000
) (
    input logic       clk,
    input logic       rst_n,
    vend_sell_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAY      = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_DONE     = 3'd3,
        ST_REFUND   = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    state_t      state_r;
    logic [1:0]  product_r;
    logic [3:0]  qty_r;
    logic [7:0]  total_r;
    logic [7:0]  paid_r;
    logic [7:0]  change_r;
    logic [3:0]  count_r [4];
    logic        done_r;
    logic        refund_r;
    logic        fail_r;
    logic [31:0] timer_r;

    logic [1:0]  sel_s;
    logic        any_sw_s;
    logic [3:0]  digit_s;
    logic [3:0]  stock_s;
    logic [7:0]  price_s;
    logic [7:0]  total_new_s;
    logic [4:0]  coin_sum_s;
    logic        coin_any_s;
    logic        cancel_s;
    logic [8:0]  paid_sum_s;
    logic [7:0]  paid_sat_s;
    logic        unused_keys_s;

    assign unused_keys_s = ^{bus.key_edge[15:14], bus.key_edge[0]};

    // Product selection by switch priority and the matching stock/price.
    always_comb begin
        any_sw_s = bus.sw1 | bus.sw2 | bus.sw3 | bus.sw4;
        if (bus.sw1) begin
            sel_s = 2'd0;
        end else if (bus.sw2) begin
            sel_s = 2'd1;
        end else if (bus.sw3) begin
            sel_s = 2'd2;
        end else begin
            sel_s = 2'd3;
        end
        case (sel_s)
            2'd0:    begin stock_s = bus.quant1; price_s = 8'(PRICE1); end
            2'd1:    begin stock_s = bus.quant2; price_s = 8'(PRICE2); end
            2'd2:    begin stock_s = bus.quant3; price_s = 8'(PRICE3); end
            2'd3:    begin stock_s = bus.quant4; price_s = 8'(PRICE4); end
            default: begin stock_s = 4'd0;       price_s = 8'd0;       end
        endcase
    end

    // One-hot digit decode; zero means no digit or several at once.
    always_comb begin
        case (bus.key_edge[9:1])
            9'b000000001: digit_s = 4'd1;
            9'b000000010: digit_s = 4'd2;
            9'b000000100: digit_s = 4'd3;
            9'b000001000: digit_s = 4'd4;
            9'b000010000: digit_s = 4'd5;
            9'b000100000: digit_s = 4'd6;
            9'b001000000: digit_s = 4'd7;
            9'b010000000: digit_s = 4'd8;
            9'b100000000: digit_s = 4'd9;
            default:      digit_s = 4'd0;
        endcase
        total_new_s = {4'd0, digit_s} * price_s;
    end

    // Coin summation with saturating accumulate.
    always_comb begin
        coin_sum_s = (bus.key_edge[10] ? 5'd1  : 5'd0)
                   + (bus.key_edge[11] ? 5'd5  : 5'd0)
                   + (bus.key_edge[12] ? 5'd10 : 5'd0);
        coin_any_s = |bus.key_edge[12:10];
        cancel_s   = bus.key_edge[13];
        paid_sum_s = 9'(paid_r) + 9'(coin_sum_s);
        if (paid_sum_s[8]) begin
            paid_sat_s = 8'd255;
        end else begin
            paid_sat_s = paid_sum_s[7:0];
        end
    end

    // Transaction FSM with all display outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            product_r <= 2'd0;
            qty_r     <= 4'd0;
            total_r   <= 8'd0;
            paid_r    <= 8'd0;
            change_r  <= 8'd0;
            done_r    <= 1'b0;
            refund_r  <= 1'b0;
            fail_r    <= 1'b0;
            timer_r   <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                count_r[i] <= 4'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_sw_s && (digit_s != 4'd0)) begin
                        product_r <= sel_s;
                        qty_r     <= digit_s;
                        timer_r   <= 32'd0;
                        if (digit_s <= stock_s) begin
                            total_r <= total_new_s;
                            paid_r  <= 8'd0;
                            state_r <= ST_PAY;
                        end else begin
                            fail_r  <= 1'b1;
                            state_r <= ST_FAIL;
                        end
                    end
                end
                ST_PAY: begin
                    if (cancel_s) begin
                        change_r <= paid_r;
                        refund_r <= 1'b1;
                        timer_r  <= 32'd0;
                        state_r  <= ST_REFUND;
                    end else if (coin_any_s) begin
                        paid_r  <= paid_sat_s;
                        timer_r <= 32'd0;
                        if (paid_sat_s >= total_r) begin
                            state_r <= ST_DISPENSE;
                        end
                    // The coin cycle itself counts toward the timeout window.
                    end else if (timer_r == 32'(TIMEOUT - 2)) begin
                        change_r <= paid_r;
                        refund_r <= 1'b1;
                        timer_r  <= 32'd0;
                        state_r  <= ST_REFUND;
                    end else begin
                        timer_r <= timer_r + 32'd1;
                    end
                end
                ST_DISPENSE: begin
                    count_r[product_r] <= count_r[product_r] + qty_r;
                    change_r <= paid_r - total_r;
                    done_r   <= 1'b1;
                    timer_r  <= 32'd0;
                    state_r  <= ST_DONE;
                end
                ST_DONE, ST_REFUND, ST_FAIL: begin
                    if (timer_r == 32'(HOLD - 1)) begin
                        qty_r    <= 4'd0;
                        total_r  <= 8'd0;
                        paid_r   <= 8'd0;
                        change_r <= 8'd0;
                        done_r   <= 1'b0;
                        refund_r <= 1'b0;
                        fail_r   <= 1'b0;
                        timer_r  <= 32'd0;
                        state_r  <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + 32'd1;
                    end
                end
                default: begin
                    timer_r <= 32'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state   = state_r;
    assign bus.product = product_r;
    assign bus.qty     = qty_r;
    assign bus.total   = total_r;
    assign bus.paid    = paid_r;
    assign bus.change  = change_r;
    assign bus.done    = done_r;
    assign bus.refund  = refund_r;
    assign bus.fail    = fail_r;
    assign bus.count1  = count_r[0];
    assign bus.count2  = count_r[1];
    assign bus.count3  = count_r[2];
    assign bus.count4  = count_r[3];

endmodule

// File: tb/tb_vend_sell.sv
// Bench for vend_sell: directed scenarios with literal expectations, then
// randomized keypad/switch/stock traffic against a deadline-based model.
module tb_vend_sell;
    localparam int TO = 16;
    localparam int HD = 4;
    localparam int PRICE [4] = '{3, 5, 7, 10};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vend_sell_if bus ();

    vend_sell #(.TIMEOUT(TO), .HOLD(HD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: absolute edge deadlines instead of counters.
    int         m_state, m_product, m_qty, m_total, m_paid, m_change;
    logic [3:0] m_count [4];
    longint     edge_no, refund_at, hold_at;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_product = 0; m_qty = 0; m_total = 0; m_paid = 0; m_change = 0;
            for (int i = 0; i < 4; i++) m_count[i] = 4'd0;
            edge_no = 0; refund_at = 0; hold_at = 0;
        end else begin
            int coins, d, p;
            int stock [4];
            edge_no++;
            stock = '{int'(bus.quant1), int'(bus.quant2), int'(bus.quant3), int'(bus.quant4)};
            coins = (bus.key_edge[10] ? 1 : 0) + (bus.key_edge[11] ? 5 : 0) + (bus.key_edge[12] ? 10 : 0);
            case (m_state)
                0: if ($countones(bus.key_edge[9:1]) == 1 && (bus.sw1 || bus.sw2 || bus.sw3 || bus.sw4)) begin
                    d = 0;
                    for (int i = 1; i <= 9; i++) if (bus.key_edge[i]) d = i;
                    p = bus.sw1 ? 0 : bus.sw2 ? 1 : bus.sw3 ? 2 : 3;
                    m_product = p;
                    m_qty = d;
                    if (d <= stock[p]) begin
                        m_total = d * PRICE[p];
                        m_paid = 0;
                        m_state = 1;
                        refund_at = edge_no + TO - 1;
                    end else begin
                        m_state = 5;
                        hold_at = edge_no + HD;
                    end
                end
                1: if (bus.key_edge[13]) begin
                    m_change = m_paid; m_state = 4; hold_at = edge_no + HD;
                end else if (coins > 0) begin
                    m_paid = (m_paid + coins > 255) ? 255 : m_paid + coins;
                    refund_at = edge_no + TO - 1;
                    if (m_paid >= m_total) m_state = 2;
                end else if (edge_no == refund_at) begin
                    m_change = m_paid; m_state = 4; hold_at = edge_no + HD;
                end
                2: begin
                    m_count[m_product] = m_count[m_product] + 4'(m_qty);
                    m_change = m_paid - m_total;
                    m_state = 3;
                    hold_at = edge_no + HD;
                end
                default: if (edge_no == hold_at) begin
                    m_state = 0; m_qty = 0; m_total = 0; m_paid = 0; m_change = 0;
                end
            endcase
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("state",   32'(bus.state),   32'(m_state));
        chk("product", 32'(bus.product), 32'(m_product));
        chk("qty",     32'(bus.qty),     32'(m_qty));
        chk("total",   32'(bus.total),   32'(m_total));
        chk("paid",    32'(bus.paid),    32'(m_paid));
        chk("change",  32'(bus.change),  32'(m_change));
        chk("done",    32'(bus.done),    32'(m_state == 3));
        chk("refund",  32'(bus.refund),  32'(m_state == 4));
        chk("fail",    32'(bus.fail),    32'(m_state == 5));
        chk("count1",  32'(bus.count1),  32'(m_count[0]));
        chk("count2",  32'(bus.count2),  32'(m_count[1]));
        chk("count3",  32'(bus.count3),  32'(m_count[2]));
        chk("count4",  32'(bus.count4),  32'(m_count[3]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [15:0] k);
        bus.key_edge = k;
        tick();
        bus.key_edge = 16'd0;
    endtask

    task automatic set_sw(input logic [3:0] s);
        {bus.sw4, bus.sw3, bus.sw2, bus.sw1} = s;
    endtask

    localparam logic [15:0] C1 = 16'h0400, C5 = 16'h0800, C10 = 16'h1000, CAN = 16'h2000;

    initial begin
        set_sw(4'b0000);
        bus.key_edge = 16'd0;
        {bus.quant1, bus.quant2, bus.quant3, bus.quant4} = 16'd0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_paid",  32'(bus.paid),  32'd0);
        rst_n = 1'b1;
        tick();

        // Product 2, qty 2, one coin 10.
        bus.quant2 = 4'd9; set_sw(4'b0010);
        press(16'd1 << 2);
        chk("t1_state", 32'(bus.state), 32'd1);
        chk("t1_total", 32'(bus.total), 32'd10);
        press(C10);
        chk("t1_paid",  32'(bus.paid),  32'd10);
        chk("t1_disp",  32'(bus.state), 32'd2);
        tick();
        chk("t1_count2", 32'(bus.count2), 32'd2);
        chk("t1_change", 32'(bus.change), 32'd0);
        repeat (HD - 1) tick();
        chk("t1_done_held", 32'(bus.done), 32'd1);
        tick();
        chk("t1_idle",  32'(bus.state), 32'd0);
        chk("t1_clear", 32'({bus.qty, bus.total, bus.paid, bus.change}), 32'd0);

        // sw1 wins over sw3, qty 3 at price 3, coins 5 + 5.
        bus.quant1 = 4'd4; set_sw(4'b0101);
        press(16'd1 << 3);
        chk("t2_product", 32'(bus.product), 32'd0);
        chk("t2_total",   32'(bus.total),   32'd9);
        press(C5);
        press(C5);
        chk("t2_paid", 32'(bus.paid), 32'd10);
        tick();
        chk("t2_change", 32'(bus.change), 32'd1);
        chk("t2_count1", 32'(bus.count1), 32'd3);
        repeat (HD) tick();

        // Insufficient stock.
        bus.quant4 = 4'd2; set_sw(4'b1000);
        press(16'd1 << 5);
        chk("t3_state", 32'(bus.state), 32'd5);
        chk("t3_fail",  32'(bus.fail),  32'd1);
        chk("t3_qty",   32'(bus.qty),   32'd5);
        chk("t3_counts", 32'({bus.count1, bus.count2, bus.count3, bus.count4}), 32'h3200);
        repeat (HD) tick();

        // Cancel beats a simultaneous coin.
        bus.quant4 = 4'd9;
        press(16'd1 << 1);
        chk("t4_total", 32'(bus.total), 32'd10);
        press(C5);
        press(C10 | CAN);
        chk("t4_state",  32'(bus.state),  32'd4);
        chk("t4_change", 32'(bus.change), 32'd5);
        chk("t4_count4", 32'(bus.count4), 32'd0);
        repeat (HD) tick();

        // Timeout after a single coin 1.
        bus.quant1 = 4'd9; set_sw(4'b0001);
        press(16'd1 << 9);
        chk("t5_total", 32'(bus.total), 32'd27);
        press(C1);
        repeat (TO - 2) tick();
        chk("t5_still_pay", 32'(bus.state), 32'd1);
        tick();
        chk("t5_refund", 32'(bus.state),  32'd4);
        chk("t5_change", 32'(bus.change), 32'd1);
        repeat (HD) tick();

        // Reset in the middle of PAY.
        press(16'd1 << 4);
        press(C5);
        press(C1);
        chk("t6_paid", 32'(bus.paid), 32'd6);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 32'(bus.state), 32'd0);
        chk("t6_rst_outs", 32'({bus.paid, bus.total, bus.qty, bus.count1, bus.count2}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        press(16'd1 << 2);
        chk("t6_fresh_state", 32'(bus.state), 32'd1);
        chk("t6_fresh_paid",  32'(bus.paid),  32'd0);
        chk("t6_fresh_total", 32'(bus.total), 32'd6);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [15:0] k;
            tick();
            if ($urandom_range(0, 9) == 0) set_sw(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 19) == 0) begin
                bus.quant1 = 4'($urandom_range(0, 15));
                bus.quant2 = 4'($urandom_range(0, 15));
                bus.quant3 = 4'($urandom_range(0, 15));
                bus.quant4 = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 99);
            k = 16'd0;
            if (r < 8) k[$urandom_range(1, 9)] = 1'b1;
            else if (r < 10) begin k[$urandom_range(1, 9)] = 1'b1; k[$urandom_range(1, 9)] = 1'b1; end
            else if (r < 18) k[12:10] = 3'($urandom_range(1, 7));
            else if (r < 20) begin k[13] = 1'b1; k[12:10] = 3'($urandom_range(0, 7)); end
            bus.key_edge = k;
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        tick();
        bus.key_edge = 16'd0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
